// File: rtl/gray_seq_ctrl.sv
// Command-driven up/down sequencer that presents a binary count and its Gray
// code, both registered on the same edge, with one-shot or wrapping runs.
module gray_seq_ctrl #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [W-1:0] cmd_len,
   input  logic         cmd_dir,
   input  logic         cmd_wrap,
   input  logic         step_en,
   output logic [W-1:0] bin_out,
   output logic [W-1:0] gray_out,
   output logic         busy,
   output logic         done,
   output logic         wrap_pulse,
   output logic         cmd_err
);

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_STOP   = 2'b01;
   localparam logic [1:0] OP_PAUSE  = 2'b10;
   localparam logic [1:0] OP_RESUME = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   bin_q, bin_n;
   logic [W-1:0]   gray_q, gray_n;
   logic [W-1:0]   len_q, len_n;
   logic           dir_q, dir_n;
   logic           wrap_q, wrap_n;
   logic           done_q, done_n;
   logic           wrp_q, wrp_n;
   logic           err_q, err_n;
   logic           accept;
   logic [W-1:0]   end_val;
   logic [W-1:0]   start_val;

   function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign cmd_ready  = (state != S_DONE);
   assign accept     = cmd_valid && cmd_ready;
   assign end_val    = dir_q ? '0 : len_q;
   assign start_val  = dir_q ? len_q : '0;

   assign bin_out    = bin_q;
   assign gray_out   = gray_q;
   assign busy       = (state == S_RUN) || (state == S_PAUSE);
   assign done       = done_q;
   assign wrap_pulse = wrp_q;
   assign cmd_err    = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         bin_q  <= '0;
         gray_q <= '0;
         len_q  <= '0;
         dir_q  <= 1'b0;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
         wrp_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_n;
         bin_q  <= bin_n;
         gray_q <= gray_n;
         len_q  <= len_n;
         dir_q  <= dir_n;
         wrap_q <= wrap_n;
         done_q <= done_n;
         wrp_q  <= wrp_n;
         err_q  <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      bin_n   = bin_q;
      len_n   = len_q;
      dir_n   = dir_q;
      wrap_n  = wrap_q;
      done_n  = 1'b0;
      wrp_n   = 1'b0;
      err_n   = 1'b0;

      case (state)
         S_IDLE: begin
            if (accept) begin
               if (cmd_op == OP_START) begin
                  state_n = S_RUN;
                  len_n   = cmd_len;
                  dir_n   = cmd_dir;
                  wrap_n  = cmd_wrap;
                  bin_n   = cmd_dir ? cmd_len : '0;
               end else begin
                  err_n = 1'b1;
               end
            end
         end

         S_RUN: begin
            // An accepted command takes priority and swallows this cycle's step.
            if (accept) begin
               case (cmd_op)
                  OP_STOP: begin
                     state_n = S_DONE;
                     done_n  = 1'b1;
                  end
                  OP_PAUSE: state_n = S_PAUSE;
                  default:  err_n   = 1'b1;
               endcase
            end else if (step_en) begin
               if (bin_q == end_val) begin
                  if (wrap_q) begin
                     bin_n = start_val;
                     wrp_n = 1'b1;
                  end else begin
                     state_n = S_DONE;
                     done_n  = 1'b1;
                  end
               end else if (dir_q) begin
                  bin_n = bin_q - 1'b1;
               end else begin
                  bin_n = bin_q + 1'b1;
               end
            end
         end

         S_PAUSE: begin
            if (accept) begin
               case (cmd_op)
                  OP_RESUME: state_n = S_RUN;
                  OP_STOP: begin
                     state_n = S_DONE;
                     done_n  = 1'b1;
                  end
                  default:   err_n = 1'b1;
               endcase
            end
         end

         S_DONE: state_n = S_IDLE;

         default: state_n = S_IDLE;
      endcase

      gray_n = bin2gray(bin_n);
   end

endmodule
